// File: rtl/mem_stage_dcache.sv
// rtl/mem_stage_dcache.sv - MEM stage: store forwarding plus direct-mapped write-through, no-write-allocate D-cache
// Optional hit/miss counters are enabled by defining MEM_STAGE_PERF_EN.
module mem_stage_dcache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] MemWd,
  input  logic [31:0] ExtImm_WB,
  input  logic [31:0] ALUres_WB,
  input  logic [31:0] MemRd_WB,
  input  logic [1:0]  MemWd_Fwd_ctr,
  input  logic [31:0] ALUres_MEM,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  output logic [31:0] MemRd,
  output logic        mem_stall,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
`ifdef MEM_STAGE_PERF_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  localparam int WB    = $clog2(LINE_WORDS);
  localparam int IB    = $clog2(NUM_LINES);
  localparam int AW    = WB + IB;
  localparam int TW    = 30 - AW;
  localparam int BW    = (WB > 0) ? WB : 1;
  localparam int DEPTH = NUM_LINES * LINE_WORDS;
  localparam logic [31:0]   LINE_MASK = 32'(LINE_WORDS * 4 - 1);
  localparam logic [AW-1:0] WORD_MASK = AW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_REFILL, S_WRITE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TW-1:0]       tag_mem  [NUM_LINES];
  logic [31:0]         data_mem [DEPTH];

  logic [1:0]    off;
  logic [AW-1:0] didx;
  logic [IB-1:0] lidx;
  logic [TW-1:0] tag;
  logic          hit, is_byte, is_half, last_beat;
  logic [31:0]   cur_word, st_src, st_data, merged, ld_shift, ld_data, line_base;
  logic [3:0]    st_be;
  logic          dwe, twe;
  logic [AW-1:0] dwaddr;
  logic [31:0]   dwdata;

  // data array is indexed by {line, word}, which is a contiguous address slice
  assign off       = ALUres_MEM[1:0];
  assign didx      = ALUres_MEM[2 +: AW];
  assign lidx      = ALUres_MEM[2+WB +: IB];
  assign tag       = ALUres_MEM[31 -: TW];
  assign hit       = valid_q[lidx] && (tag_mem[lidx] == tag);
  assign cur_word  = data_mem[didx];
  assign is_byte   = (mem_size == 2'd0);
  assign is_half   = (mem_size == 2'd1);
  assign misalign  = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
  assign last_beat = (beat_q == BW'(LINE_WORDS - 1));
  assign line_base = {ALUres_MEM[31:2], 2'b00} & ~LINE_MASK;

  always_comb begin
    case (MemWd_Fwd_ctr)
      2'd0:    st_src = MemWd;
      2'd1:    st_src = ExtImm_WB;
      2'd2:    st_src = ALUres_WB;
      default: st_src = MemRd_WB;
    endcase
    st_be   = 4'hF;
    st_data = st_src;
    if (is_byte) begin
      st_be   = 4'b0001 << off;
      st_data = {4{st_src[7:0]}};
    end else if (is_half) begin
      st_be   = 4'b0011 << off;
      st_data = {2{st_src[15:0]}};
    end
    merged = cur_word;
    for (int i = 0; i < 4; i++) begin
      if (st_be[i]) merged[8*i +: 8] = st_data[8*i +: 8];
    end
    ld_shift = cur_word >> {off, 3'b000};
    if (is_byte)      ld_data = {{24{!mem_unsigned && ld_shift[7]}}, ld_shift[7:0]};
    else if (is_half) ld_data = {{16{!mem_unsigned && ld_shift[15]}}, ld_shift[15:0]};
    else              ld_data = cur_word;
  end

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    valid_d   = valid_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_be    = 4'h0;
    mem_stall = 1'b0;
    MemRd     = 32'h0;
    dwe       = 1'b0;
    twe       = 1'b0;
    dwaddr    = didx;
    dwdata    = merged;
    case (state_q)
      S_IDLE: begin
        if (!misalign && MemRead) begin
          if (hit) begin
            MemRd = ld_data;
          end else begin
            mem_stall = 1'b1;
            beat_d    = '0;
            state_d   = S_REFILL;
          end
        end else if (!misalign && MemWrite) begin
          mem_stall = 1'b1;
          state_d   = S_WRITE;
        end
      end
      S_REFILL: begin
        mem_stall = 1'b1;
        mem_req   = 1'b1;
        mem_addr  = line_base | 32'({beat_q, 2'b00});
        if (mem_ack) begin
          dwe    = 1'b1;
          dwaddr = (didx & ~WORD_MASK) | AW'(beat_q);
          dwdata = mem_rdata;
          if (last_beat) begin
            valid_d[lidx] = 1'b1;
            twe           = 1'b1;
            beat_d        = '0;
            state_d       = S_IDLE;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end
      end
      S_WRITE: begin
        mem_stall = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ALUres_MEM[31:2], 2'b00};
        mem_wdata = st_data;
        mem_be    = st_be;
        if (mem_ack) begin
          dwe     = hit;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (dwe) data_mem[dwaddr] <= dwdata;
    if (twe) tag_mem[lidx]    <= tag;
  end

`ifdef MEM_STAGE_PERF_EN
  logic        recheck_q, recheck_d, hit_ret, miss_go;
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  // the hit that follows a refill belongs to the miss already counted
  assign hit_ret = (state_q == S_IDLE) && MemRead && !misalign && hit && !recheck_q;
  assign miss_go = (state_q == S_IDLE) && (state_d == S_REFILL);

  always_comb begin
    recheck_d  = (state_q == S_REFILL) && (state_d == S_IDLE);
    hit_cnt_d  = hit_cnt_q + {31'h0, hit_ret};
    miss_cnt_d = miss_cnt_q + {31'h0, miss_go};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      recheck_q  <= 1'b0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      recheck_q  <= recheck_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_mem_stage_dcache.sv
// tb/tb_mem_stage_dcache.sv - self-checking bench for mem_stage_dcache
module tb_mem_stage_dcache;
  localparam int LW = 4;
  localparam int NL = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] MemWd, ExtImm_WB, ALUres_WB, MemRd_WB, ALUres_MEM, MemRd, mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  MemWd_Fwd_ctr, mem_size;
  logic        MemRead, MemWrite, mem_unsigned, mem_stall, misalign, mem_req, mem_we, mem_ack;
  logic [3:0]  mem_be;
`ifdef MEM_STAGE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  mem_stage_dcache #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
    .clk(clk), .rst(rst), .MemWd(MemWd), .ExtImm_WB(ExtImm_WB), .ALUres_WB(ALUres_WB),
    .MemRd_WB(MemRd_WB), .MemWd_Fwd_ctr(MemWd_Fwd_ctr), .ALUres_MEM(ALUres_MEM),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_size(mem_size), .mem_unsigned(mem_unsigned),
    .MemRd(MemRd), .mem_stall(mem_stall), .misalign(misalign), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
`ifdef MEM_STAGE_PERF_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // main memory as seen on the bus, and the value each word should hold
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] shadow  [int unsigned];
  int unsigned addr_log [$];
  int          lat_fixed;
  bit          ref_v   [NL];
  int unsigned ref_tag [NL];
  int          ref_hits, ref_misses;

  function automatic logic [31:0] mem_word(input int unsigned wa);
    if (!ref_mem.exists(wa)) ref_mem[wa] = $urandom;
    return ref_mem[wa];
  endfunction

  function automatic logic [31:0] sh_word(input int unsigned wa);
    if (!shadow.exists(wa)) shadow[wa] = mem_word(wa);
    return shadow[wa];
  endfunction

  function automatic int next_lat();
    return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
  endfunction

  function automatic bit is_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd1 && off[0]) || (sz >= 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off,
                                          input logic [1:0] sz, input bit un);
    logic [31:0] s;
    s = w >> (8 * off);
    if (sz == 2'd0) begin
      s = s & 32'hFF;
      if (!un && s >= 32'h80) s = s | 32'hFFFFFF00;
    end else if (sz == 2'd1) begin
      s = s & 32'hFFFF;
      if (!un && s >= 32'h8000) s = s | 32'hFFFF0000;
    end
    return s;
  endfunction

  task automatic exp_lanes(input logic [1:0] sz, input logic [1:0] off, input logic [31:0] v,
                           output logic [3:0] be, output logic [31:0] wd);
    if (sz == 2'd0) begin be = 4'd1 << off; wd = {4{v[7:0]}}; end
    else if (sz == 2'd1) begin be = 4'd3 << off; wd = {2{v[15:0]}}; end
    else begin be = 4'hF; wd = v; end
  endtask

  task automatic model_load(input logic [31:0] a, input logic [1:0] sz, input bit un,
                            output logic [31:0] exp, output bit hit);
    int unsigned ln, tg;
    ln  = (a / (LW * 4)) % NL;
    tg  = a / (LW * 4 * NL);
    hit = ref_v[ln] && ref_tag[ln] == tg;
    if (hit) ref_hits++;
    else begin ref_misses++; ref_v[ln] = 1'b1; ref_tag[ln] = tg; end
    exp = extract(sh_word(a >> 2), a[1:0], sz, un);
  endtask

  task automatic model_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] w;
    w = sh_word(a >> 2);
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    shadow[a >> 2] = w;
  endtask

  // bus responder: acks after a programmable number of wait cycles
  initial begin
    int cnt;
    logic [31:0] w;
    mem_ack = 1'b0; mem_rdata = 32'h0; cnt = 0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (rst || !mem_req) cnt = next_lat();
      else if (cnt == 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          w = mem_word(mem_addr >> 2);
          for (int i = 0; i < 4; i++) if (mem_be[i]) w[8*i +: 8] = mem_wdata[8*i +: 8];
          ref_mem[mem_addr >> 2] = w;
        end else begin
          mem_rdata = mem_word(mem_addr >> 2);
          addr_log.push_back(mem_addr);
        end
        cnt = next_lat();
      end else cnt--;
    end
  end

  task automatic access(input bit ld, input bit st, input logic [31:0] a, input logic [1:0] sz,
                        input bit un, input logic [1:0] fwd, input logic [31:0] wv,
                        output logic [31:0] rd, output int stalls, output bit mis,
                        output bit anyreq, output logic [3:0] be, output logic [31:0] wd);
    MemRead = ld; MemWrite = st; ALUres_MEM = a; mem_size = sz; mem_unsigned = un;
    MemWd_Fwd_ctr = fwd;
    MemWd = $urandom; ExtImm_WB = $urandom; ALUres_WB = $urandom; MemRd_WB = $urandom;
    case (fwd)
      2'd0: MemWd = wv;
      2'd1: ExtImm_WB = wv;
      2'd2: ALUres_WB = wv;
      default: MemRd_WB = wv;
    endcase
    stalls = 0; anyreq = 1'b0; be = 4'h0; wd = 32'h0; rd = 32'h0; mis = 1'b0;
    while (1) begin
      @(negedge clk);
      if (mem_req) anyreq = 1'b1;
      if (mem_req && mem_we) begin be = mem_be; wd = mem_wdata; end
      if (!mem_stall) begin rd = MemRd; mis = misalign; break; end
      stalls++;
      if (stalls > 500) begin
        total++;
        $display("FAIL access_timeout: got stalled at %h expected completion", a);
        break;
      end
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  typedef struct {
    bit ld; bit st; logic [31:0] a; logic [1:0] sz; bit un; logic [1:0] fwd; logic [31:0] wv;
    logic [31:0] xd; int xs; bit xm; logic [3:0] xbe; logic [31:0] xwd;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [31:0] rd, wd, xd, xwd;
    logic [3:0]  be, xbe;
    int          stalls;
    bit          mis, anyreq, hit, found, ld, st, un;
    logic [31:0] a, wv;
    logic [1:0]  sz, fwd;

    // ld st addr sz un fwd wv | data stalls mis be wdata   (latency 2)
    tbl.push_back('{1, 0, 32'h100, 2, 0, 0, 0, 32'h000000A0, 13, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h104, 2, 0, 0, 0, 32'h000000A1, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h108, 2, 0, 0, 32'h80FF7F01, 0, 4, 0, 4'hF, 32'h80FF7F01});
    tbl.push_back('{1, 0, 32'h10B, 0, 0, 0, 0, 32'hFFFFFF80, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h10B, 0, 1, 0, 0, 32'h00000080, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h10A, 1, 0, 0, 0, 32'hFFFF80FF, 0, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h108, 1, 1, 0, 0, 32'h00007F01, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h101, 0, 0, 0, 32'h12345655, 0, 4, 0, 4'b0010, 32'h55555555});
    tbl.push_back('{1, 0, 32'h100, 2, 0, 0, 0, 32'h000055A0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h2000, 2, 0, 3, 32'hDEADBEEF, 0, 4, 0, 4'hF, 32'hDEADBEEF});
    tbl.push_back('{1, 0, 32'h2000, 2, 0, 0, 0, 32'hDEADBEEF, 13, 0, 0, 0});
    tbl.push_back('{1, 0, 32'h102, 2, 0, 0, 0, 32'h0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 32'h103, 1, 0, 0, 0, 32'h0, 0, 1, 0, 0});
    tbl.push_back('{0, 1, 32'h10A, 2, 0, 0, 32'h11111111, 0, 0, 1, 0, 0});
    tbl.push_back('{1, 0, 32'h100, 0, 0, 0, 0, 32'hFFFFFFA0, 0, 0, 0, 0});
    tbl.push_back('{0, 1, 32'h10E, 1, 0, 1, 32'h0000BEEF, 0, 4, 0, 4'b1100, 32'hBEEFBEEF});
    tbl.push_back('{1, 0, 32'h10E, 1, 0, 0, 0, 32'hFFFFBEEF, 0, 0, 0, 0});

    rst = 1'b1; lat_fixed = 2;
    MemRead = 0; MemWrite = 0; ALUres_MEM = 0; mem_size = 0; mem_unsigned = 0; MemWd_Fwd_ctr = 0;
    MemWd = 0; ExtImm_WB = 0; ALUres_WB = 0; MemRd_WB = 0;
    ref_hits = 0; ref_misses = 0;
    for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
    for (int i = 0; i < 4; i++) ref_mem[(32'h100 >> 2) + i] = 32'hA0 + i;

    @(negedge clk);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_stall", mem_stall, 0);
    check("rst_MemRd", MemRd, 0);
    check("rst_mem_addr", mem_addr, 0);
`ifdef MEM_STAGE_PERF_EN
    check("rst_hit_cnt", hit_cnt, 0);
    check("rst_miss_cnt", miss_cnt, 0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    foreach (tbl[i]) begin
      addr_log.delete();
      if (tbl[i].st && !tbl[i].xm) begin
        exp_lanes(tbl[i].sz, tbl[i].a[1:0], tbl[i].wv, xbe, xwd);
        model_store(tbl[i].a, xbe, xwd);
      end
      if (tbl[i].ld && !tbl[i].xm) model_load(tbl[i].a, tbl[i].sz, tbl[i].un, xd, hit);
      access(tbl[i].ld, tbl[i].st, tbl[i].a, tbl[i].sz, tbl[i].un, tbl[i].fwd, tbl[i].wv,
             rd, stalls, mis, anyreq, be, wd);
      check($sformatf("t%0d_data", i), rd, tbl[i].xd);
      check($sformatf("t%0d_stalls", i), stalls, tbl[i].xs);
      check($sformatf("t%0d_misalign", i), mis, tbl[i].xm);
      if (tbl[i].xm) check($sformatf("t%0d_no_req", i), anyreq, 0);
      if (tbl[i].st && !tbl[i].xm) begin
        check($sformatf("t%0d_be", i), be, tbl[i].xbe);
        check($sformatf("t%0d_wdata", i), wd, tbl[i].xwd);
      end
      if (i == 0) begin
        check("refill_beats", addr_log.size(), 4);
        for (int k = 0; k < 4 && k < addr_log.size(); k++)
          check($sformatf("refill_addr%0d", k), addr_log[k], 32'h100 + 4 * k);
      end
    end

    // reset during the second refill beat
    MemRead = 1'b1; ALUres_MEM = 32'h3000; mem_size = 2'd2; mem_unsigned = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h3004) begin found = 1'b1; break; end
    end
    check("rst_beat2_seen", found, 1);
    #1 rst = 1'b1;
    #1 check("rst_mid_req_drop", mem_req, 0);
    MemRead = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < NL; i++) ref_v[i] = 1'b0;
    ref_hits = 0; ref_misses = 0;
`ifdef MEM_STAGE_PERF_EN
    check("rst_mid_miss_cnt", miss_cnt, 0);
`endif
    model_load(32'h3000, 2'd2, 1'b0, xd, hit);
    access(1, 0, 32'h3000, 2'd2, 0, 0, 0, rd, stalls, mis, anyreq, be, wd);
    check("rst_reload_stalls", stalls, 13);
    check("rst_reload_data", rd, xd);
    model_load(32'h3004, 2'd2, 1'b0, xd, hit);
    access(1, 0, 32'h3004, 2'd2, 0, 0, 0, rd, stalls, mis, anyreq, be, wd);
    check("rst_reload_hit_stalls", stalls, 0);
    check("rst_reload_hit_data", rd, xd);

    // randomized accesses over four conflicting tags, random latency
    lat_fixed = -1;
    for (int n = 0; n < 400; n++) begin
      a   = 32'h4000 + $urandom_range(0, 3) * (LW * 4 * NL) + $urandom_range(0, 4 * LW * 4 - 1);
      ld  = $urandom_range(0, 1);
      st  = !ld;
      sz  = 2'($urandom_range(0, 3));
      un  = $urandom_range(0, 1);
      fwd = 2'($urandom_range(0, 3));
      wv  = $urandom;
      hit = 1'b0; xd = 32'h0;
      if (st && !is_mis(sz, a[1:0])) begin
        exp_lanes(sz, a[1:0], wv, xbe, xwd);
        model_store(a, xbe, xwd);
      end
      if (ld && !is_mis(sz, a[1:0])) model_load(a, sz, un, xd, hit);
      access(ld, st, a, sz, un, fwd, wv, rd, stalls, mis, anyreq, be, wd);
      check($sformatf("r%0d_misalign", n), mis, is_mis(sz, a[1:0]));
      if (is_mis(sz, a[1:0])) begin
        check($sformatf("r%0d_mis_data", n), rd, 0);
        check($sformatf("r%0d_mis_stalls", n), stalls, 0);
        check($sformatf("r%0d_mis_no_req", n), anyreq, 0);
      end else if (ld) begin
        check($sformatf("r%0d_ld_data", n), rd, xd);
        if (hit) check($sformatf("r%0d_hit_stalls", n), stalls, 0);
        else     check($sformatf("r%0d_miss_stalled", n), stalls > 0, 1);
      end else begin
        check($sformatf("r%0d_st_be", n), be, xbe);
        check($sformatf("r%0d_st_wdata", n), wd, xwd);
        check($sformatf("r%0d_st_stalls", n), stalls >= 2, 1);
      end
    end

`ifdef MEM_STAGE_PERF_EN
    check("perf_hit_cnt", hit_cnt, ref_hits);
    check("perf_miss_cnt", miss_cnt, ref_misses);
`endif
    check("final_idle_req", mem_req, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_stage_dcache.md
# mem_stage_dcache

Parametrised MEM pipeline stage combining the store-data forwarding mux with a direct-mapped, write-through, no-write-allocate data cache. It sits between EX/MEM and MEM/WB and talks to main memory over a request/acknowledge bus with arbitrary latency. It adds byte/halfword access, misalignment detection and configurable cache geometry. It holds the pipeline with `mem_stall` until each access completes.

## Interface

- `LINE_WORDS`, 4: 32-bit words per line; power of two, ≥1.
- `NUM_LINES`, 64: number of cache lines; power of two, ≥2.

- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `MemWd`, `ExtImm_WB`, `ALUres_WB`, `MemRd_WB` in 32 each: store-data forwarding sources, selected by `MemWd_Fwd_ctr` = 0/1/2/3.
- `MemWd_Fwd_ctr` in 2: forwarding select.
- `ALUres_MEM` in 32: byte address.
- `MemRead` in 1: load request.
- `MemWrite` in 1: store request. Never asserted together with `MemRead`.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word. 3 is treated as word.
- `mem_unsigned` in 1: zero-extend loads; 0 sign-extends.
- `MemRd` out 32: extended load data.
- `mem_stall` out 1: hold the pipeline.
- `misalign` out 1: the current access is misaligned.
- `mem_req` out 1: memory request.
- `mem_we` out 1: write request.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_be` out 4: memory byte enables.
- `mem_ack` in 1: request accepted/completed. Read data is valid in the same cycle.
- `mem_rdata` in 32: memory read data.

## Operation

- **Address split:**
  - offset = `addr[1:0]`
  - word = `addr[2 +: log2(LINE_WORDS)]`
  - index = next `log2(NUM_LINES)` bits
  - tag = the remaining bits
- **Storage:** per line, a valid bit, a tag and `LINE_WORDS` words.
- **Misalignment:**
  - Defined as half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `misalign`=1 combinationally.
  - No memory or cache access is made, `mem_stall`=0 and `MemRd`=0.
- **Byte lanes:**
  - byte: `be` = `1<<addr[1:0]`, data = the byte replicated ×4.
  - half: `be` = `4'b0011<<addr[1:0]`, data = the halfword replicated ×2.
  - word: `be` = `4'hF`.
- **States:** IDLE, REFILL, WRITE, DONE.
- **IDLE:**
  - Load hit: `MemRd` = the selected lanes, extended, in the same cycle; `mem_stall`=0.
  - Load miss: `mem_stall`=1 and go to REFILL with beat counter 0.
  - Store: `mem_stall`=1 and go to WRITE.
- **REFILL:**
  - `mem_req`=1, `mem_we`=0, `mem_addr` = line base + 4×beat.
  - On each `mem_ack`: write `mem_rdata` into word[beat] and increment beat.
  - On the last beat: set valid, write the tag, return to IDLE. The access then re-evaluates as a hit.
  - `mem_stall`=1 throughout.
- **WRITE:**
  - `mem_req`=1, `mem_we`=1; `mem_addr`, `mem_wdata` and `mem_be` come from the store.
  - On `mem_ack`: if the line hits, merge the enabled bytes into the cached word; go to DONE.
  - `mem_stall`=1.
- **DONE:** `mem_stall`=0 for exactly one cycle so the store retires, then IDLE. No re-issue.
- **Request stability:** `mem_req`, `mem_addr`, `mem_wdata` and `mem_be` are held stable until `mem_ack`. `mem_ack` with `mem_req`=0 is ignored.
- **Idle load data:** `MemRd`=0 when no load completes.

## Timing

- **Reset:** all valid bits 0, state IDLE, beat 0, perf counters 0.
- **Outputs:** `mem_req`, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are 0 in IDLE. `mem_stall` and `misalign` are combinational from state and inputs.
- **Load hit:** 0 extra cycles.
- **Load miss:** `LINE_WORDS` × (memory latency + 1) cycles + 1 re-check cycle.
- **Store:** memory latency + 2 cycles minimum. With `mem_ack` in the first WRITE cycle, the stall lasts 2 cycles.
- **Ack timing:** `mem_ack` may arrive in the first request cycle (zero-wait memory).
- **Reset mid-refill or mid-write:** the FSM aborts, `mem_req` drops, and no partial line becomes valid.
- **Index conflict:** a refill replaces the line unconditionally (write-through, so nothing is lost).

## Configuration

- **`MEM_STAGE_PERF_EN` defined:**
  - Adds outputs `hit_cnt` (32) and `miss_cnt` (32).
  - `hit_cnt` increments once per retired load hit in IDLE, excluding the post-refill re-check.
  - `miss_cnt` increments on each IDLE→REFILL transition.
  - Both wrap at 2^32 and reset to 0.
- **Undefined:** neither port nor its counters exist.

## Test plan

- **Cold load, then hit:** word load at 0x100, memory returns 0xA0..0xA3 with 2-cycle latency → REFILL issues 0x100, 0x104, 0x108, 0x10C. `MemRd`=0xA0 after the stall drops. A load at 0x104 next cycle returns 0xA1 with no stall.
- **Byte/half extension:** cached word 0x80FF7F01.
  - lb at +3 → 0xFFFFFF80
  - lbu at +3 → 0x00000080
  - lh at +2 → 0xFFFF80FF
  - lhu at +0 → 0x00007F01
- **Store to cached line:** sb 0x55 at 0x101 → `mem_be`=4'b0010, `mem_wdata`=0x55555555. A later load at 0x100 shows byte 1 = 0x55 with no stall. Store to an uncached address → memory written, the next load misses.
- **Forwarding:** `MemWd_Fwd_ctr`=3 with `MemRd_WB`=0xDEADBEEF on a word store → `mem_wdata`=0xDEADBEEF.
- **Misalignment and reset:**
  - lw at 0x102 → `misalign`=1, no `mem_req`, no stall.
  - Assert `rst` during the 2nd refill beat → `mem_req`=0 immediately; reloading the address misses.
- **Perf counters (`MEM_STAGE_PERF_EN` defined):** 1 miss followed by 3 hits → `miss_cnt`=1, `hit_cnt`=3.
